// File: rtl/e_digest_buffer_if.sv
// E(z) digest buffer bus: upstream digit stream, hash core memory port,
// hash start/result and downstream digest handoff.
interface e_digest_buffer_if #(
    parameter int WIDTH = 101,
    parameter int AW    = 6
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             hash_start;
    logic             mem_rw;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_din;
    logic [511:0]     hash_out;
    logic             hash_out_ready;
    logic [511:0]     digest;
    logic             digest_valid;
    logic             digest_ack;
    logic             busy;
    logic             rw_err;

    modport master (
        output wr_valid, wr_data, mem_rw, mem_addr,
        output hash_out, hash_out_ready, digest_ack,
        input  wr_ready, hash_start, mem_din,
        input  digest, digest_valid, busy, rw_err
    );

    modport slave (
        input  wr_valid, wr_data, mem_rw, mem_addr,
        input  hash_out, hash_out_ready, digest_ack,
        output wr_ready, hash_start, mem_din,
        output digest, digest_valid, busy, rw_err
    );
endinterface

// File: rtl/e_digest_buffer.sv
// E(z) digest buffer: fills from the decrypt datapath, serves the Keccak
// core's reads, then holds the captured digest until acknowledged.
module e_digest_buffer #(
    parameter int M     = 101,
    parameter int R     = 47,
    parameter int DIGIT = 1
) (
    input logic              clk,
    input logic              rst,
    e_digest_buffer_if.slave bus
);
    localparam int WIDTH = M * DIGIT;
    localparam int DEPTH = (R + DIGIT - 1) / DIGIT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_HASH  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] mem_din_q, mem_din_d;
    logic [511:0]     digest_q, digest_d;
    logic             digest_valid_q, digest_valid_d;
    logic             rw_err_q, rw_err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_fire;
    logic             serve;
    logic             rd_ok;
    logic [31:0]      addr_ext;

    assign bus.wr_ready     = (state_q == S_FILL);
    assign bus.hash_start   = (state_q == S_START);
    assign bus.busy         = (state_q != S_FILL);
    assign bus.mem_din      = mem_din_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.rw_err       = rw_err_q;

    assign wr_fire  = bus.wr_valid && (state_q == S_FILL);
    assign serve    = (state_q == S_HASH) || (state_q == S_HOLD);
    assign addr_ext = 32'(bus.mem_addr);
    assign rd_ok    = addr_ext < 32'(DEPTH);

    // Buffer storage: written only while filling, never reset.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Next-state logic for the fill/start/hash/hold sequence.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        mem_din_d      = mem_din_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        rw_err_d       = rw_err_q;

        if (serve) begin
            if (!bus.mem_rw) begin
                mem_din_d = rd_ok ? mem_q[bus.mem_addr] : '0;
            end else begin
                rw_err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_FILL: begin
                if (wr_fire) begin
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = S_START;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_HASH;
            end
            S_HASH: begin
                if (bus.hash_out_ready) begin
                    digest_d       = bus.hash_out;
                    digest_valid_d = 1'b1;
                    state_d        = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.digest_ack) begin
                    digest_valid_d = 1'b0;
                    state_d        = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Control and output registers; reset drops any partial fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FILL;
            wr_ptr_q       <= '0;
            mem_din_q      <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            rw_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            mem_din_q      <= mem_din_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            rw_err_q       <= rw_err_d;
        end
    end
endmodule

// File: doc/e_digest_buffer.md
Name: e_digest_buffer

Overview:
- Responder end of the Keccak wrapper's E(z) memory-read interface, replacing the external E memory.
- Accepts E(z) digits streamed from the upstream decrypt datapath into an internal buffer.
- When the buffer is full, it issues the hash start pulse, then answers the hash core's address reads with registered data.
- Captures the 512-bit digest and holds it for the downstream consumer until acknowledged.

Parameters:
- M, 101, bit width of one field element (GF(2^m) word).
- R, 47, number of field elements in E(z).
- DIGIT, 1, field elements packed per buffer word.
- WIDTH, M*DIGIT, buffer word width (derived).
- DEPTH, ceil(R/DIGIT), number of buffer words (derived); must be >= 2.
- AW, clog2(DEPTH), address width (derived).

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  upstream digit valid.
- wr_ready  output  1  buffer accepts a digit this cycle.
- wr_data  input  WIDTH  upstream digit.
- hash_start  output  1  one-cycle start pulse to the hash core's in_ready.
- mem_rw  input  1  hash core access type; 0 = read.
- mem_addr  input  AW  hash core read address.
- mem_din  output  WIDTH  read data returned to the hash core.
- hash_out  input  512  digest from the hash core.
- hash_out_ready  input  1  digest valid from the hash core; may stay high for several cycles.
- digest  output  512  captured digest.
- digest_valid  output  1  digest held for consumer.
- digest_ack  input  1  consumer has taken the digest.
- busy  output  1  high in any state other than FILL.
- rw_err  output  1  sticky flag; set when a write attempt is seen.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to FILL; wr_ptr = 0.
  - All outputs are 0, except wr_ready, which is 1 once state = FILL.
  - Buffer contents are not reset.
- States: FILL, START, HASH, HOLD.
- FILL:
  - wr_ready = 1.
  - On wr_valid & wr_ready: buf[wr_ptr] <= wr_data; wr_ptr increments.
  - When a write lands at wr_ptr == DEPTH-1: wr_ptr <= 0, go to START.
- START:
  - wr_ready = 0; hash_start = 1 for exactly this one cycle; then go to HASH.
- HASH:
  - wr_ready = 0.
  - Every cycle with mem_rw == 0: mem_din <= buf[mem_addr], giving 1-cycle read latency (matches DELAY_rd = 1).
  - If mem_addr >= DEPTH: mem_din <= 0.
  - If mem_rw == 1: buffer is unchanged, mem_din holds its value, rw_err is set (cleared only by reset).
  - On the first cycle with hash_out_ready == 1: digest <= hash_out, digest_valid <= 1, go to HOLD.
- HOLD:
  - digest and digest_valid are held.
  - hash_out_ready is ignored, so it cannot recapture while it stays high.
  - Reads are still served.
  - On digest_ack: digest_valid <= 0 next cycle, go to FILL; digest keeps its old value.
  - digest_ack outside HOLD is ignored.
- Simultaneous digest_ack and wr_valid in the HOLD exit cycle: no write occurs, because wr_ready = 0 in HOLD.
- hash_out_ready asserted during FILL or START is ignored.
- busy = (state != FILL).
- mem_din is registered in all states. It updates only in HASH and HOLD; otherwise it holds its value.
- Reset asserted mid-operation (any state): immediate return to FILL, partial fill is discarded (wr_ptr = 0), digest_valid = 0, hash_start = 0.

Test Plan:
- Reset release, then 47 writes of wr_data = index (0..46), back-to-back → wr_ready stays 1 through write 46, drops the cycle after; hash_start = 1 for exactly one cycle, 1 cycle later; busy = 1.
- In HASH, drive mem_addr = 5, then 46, then 47 on consecutive cycles → mem_din = 5, 46, 0 one cycle after each address.
- Throttled fill: wr_valid toggles every other cycle → exactly 47 writes accepted; hash_start fires once only after the 47th; no write lost or duplicated.
- hash_out_ready held high 3 cycles, hash_out = 0xA5 repeated → digest captured from the first cycle, digest_valid = 1; a hash_out change in cycles 2–3 is not captured.
- digest_ack pulsed together with wr_valid → digest_valid = 0 next cycle, state FILL, busy = 0; the concurrent write is not stored, and the next write lands at address 0.
- mem_rw = 1 in HASH → rw_err = 1 and stays set; buffer contents unchanged on readback. Reset asserted after 20 writes → wr_ptr = 0; the next full fill of 47 writes is needed for hash_start.
